spi_burst_sequencer: RTL and testbench

SPI_BURST_SEQUENCER -- requirements
Module: spi_burst_sequencer

---
 rtl/spi_burst_sequencer.sv | 120 ++++++++++++
 tb/tb_spi_burst_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_sequencer.sv
// Drives an SPI master's register port to run a 1-4 byte full-duplex burst with SS_n held low.
// Each register access is 2 active cycles plus 1 idle cycle; waits on trdy/rrdy are bounded by TIMEOUT.
module spi_burst_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'd8000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  len,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        spi_select,
  output logic [2:0]  mem_addr,
  output logic        read_n,
  output logic        write_n,
  output logic [15:0] spi_wrdata,
  input  logic [15:0] spi_rddata,
  input  logic        spi_trdy,
  input  logic        spi_rrdy
);

  typedef enum logic [3:0] {
    IDLE, SSO_ON, STAT_CLR, WAIT_TRDY, WR_TX, WAIT_RRDY, RD_RX, SSO_OFF, FINISH
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  ph;
  logic [1:0]  idx;
  logic [1:0]  last_idx;
  logic [15:0] wait_cnt;
  logic [31:0] tx_q;
  logic        acc_state;
  logic        acc_active;
  logic        in_wait;
  logic        timeout_hit;
  logic        len_ok;
  logic        unused_rddata;

  assign unused_rddata = &{1'b0, spi_rddata[15:8]};

  assign len_ok      = (len != 3'd0) && (len <= 3'd4);
  assign in_wait     = (state == WAIT_TRDY) || (state == WAIT_RRDY);
  assign timeout_hit = (wait_cnt == TIMEOUT - 16'd1);
  assign acc_state   = (state == SSO_ON) || (state == STAT_CLR) || (state == WR_TX) ||
                       (state == RD_RX) || (state == SSO_OFF);
  // ph 0/1 are the two strobe cycles, ph 2 is the mandatory idle gap
  assign acc_active  = acc_state && (ph != 2'd2);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = len_ok ? SSO_ON : FINISH;
      SSO_ON:    if (ph == 2'd2) state_nx = STAT_CLR;
      STAT_CLR:  if (ph == 2'd2) state_nx = WAIT_TRDY;
      WAIT_TRDY: if (spi_trdy) state_nx = WR_TX;
                 else if (timeout_hit) state_nx = SSO_OFF;
      WR_TX:     if (ph == 2'd2) state_nx = WAIT_RRDY;
      WAIT_RRDY: if (spi_rrdy) state_nx = RD_RX;
                 else if (timeout_hit) state_nx = SSO_OFF;
      RD_RX:     if (ph == 2'd2) state_nx = (idx == last_idx) ? SSO_OFF : WAIT_TRDY;
      SSO_OFF:   if (ph == 2'd2) state_nx = FINISH;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    spi_select = acc_active;
    read_n     = !(acc_active && (state == RD_RX));
    write_n    = !(acc_active && (state != RD_RX));
    mem_addr   = 3'd0;
    spi_wrdata = 16'h0000;
    busy       = (state != IDLE) && (state != FINISH);
    done       = (state == FINISH);
    if (acc_active) begin
      case (state)
        SSO_ON:   begin mem_addr = 3'd3; spi_wrdata = 16'h0400; end
        STAT_CLR: begin mem_addr = 3'd2; spi_wrdata = 16'h0000; end
        WR_TX:    begin mem_addr = 3'd1; spi_wrdata = {8'h00, tx_q[{idx, 3'b000} +: 8]}; end
        RD_RX:    begin mem_addr = 3'd0; spi_wrdata = 16'h0000; end
        SSO_OFF:  begin mem_addr = 3'd3; spi_wrdata = 16'h0000; end
        default:  begin mem_addr = 3'd0; spi_wrdata = 16'h0000; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ph       <= 2'd0;
      idx      <= 2'd0;
      last_idx <= 2'd0;
      wait_cnt <= 16'd0;
      tx_q     <= 32'd0;
      rx_data  <= 32'd0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      ph       <= (acc_state && (state_nx == state)) ? ph + 2'd1 : 2'd0;
      wait_cnt <= (in_wait && (state_nx == state)) ? wait_cnt + 16'd1 : 16'd0;
      if ((state == IDLE) && start) begin
        if (len_ok) begin
          tx_q     <= tx_data;
          last_idx <= len[1:0] - 2'd1;
          idx      <= 2'd0;
          err      <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (in_wait && (state_nx == SSO_OFF)) err <= 1'b1;
      if ((state == RD_RX) && (ph == 2'd1)) rx_data[{idx, 3'b000} +: 8] <= spi_rddata[7:0];
      if ((state == RD_RX) && (ph == 2'd2) && (idx != last_idx)) idx <= idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer against a loopback SPI master register model.
module tb_spi_burst_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  len = 3'd0;
  logic [31:0] tx_data = 32'd0;
  logic [31:0] rx_data;
  logic        busy, done, err, spi_select, read_n, write_n;
  logic [2:0]  mem_addr;
  logic [15:0] spi_wrdata;
  logic [15:0] spi_rddata = 16'h0000;
  logic        spi_trdy = 1'b1;
  logic        spi_rrdy = 1'b0;
  logic        rrdy_en = 1'b1;

  int checks = 0;
  int errors = 0;

  spi_burst_sequencer #(.TIMEOUT(16'd20)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .tx_data(tx_data),
    .rx_data(rx_data), .busy(busy), .done(done), .err(err), .spi_select(spi_select),
    .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n), .spi_wrdata(spi_wrdata),
    .spi_rddata(spi_rddata), .spi_trdy(spi_trdy), .spi_rrdy(spi_rrdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SPI master register model with MISO looped to MOSI
  logic        m_prev_sel = 1'b0, m_sso = 1'b0, m_rd = 1'b0, m_first;
  logic [15:0] m_pend = 16'h0000;
  int          m_dly = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_prev_sel = 1'b0; m_sso = 1'b0; m_rd = 1'b0; m_dly = 0;
      spi_rrdy = 1'b0; spi_trdy = 1'b1;
    end else begin
      m_first = spi_select && !m_prev_sel;
      if (m_first && !write_n && mem_addr == 3'd1) begin
        chk(m_sso == 1'b1, "ss_low_on_tx", 64'(m_sso), 64'd1);
        m_pend = spi_wrdata; m_dly = 4; spi_trdy = 1'b0;
      end else if (m_dly > 0) begin
        m_dly--;
        if (m_dly == 0) begin
          spi_rddata = m_pend; spi_trdy = 1'b1;
          if (rrdy_en) spi_rrdy = 1'b1;
        end
      end
      if (m_first && !write_n && mem_addr == 3'd3) m_sso = spi_wrdata[10];
      if (m_first && !read_n) m_rd = 1'b1;
      if (!spi_select && m_prev_sel && m_rd) begin spi_rrdy = 1'b0; m_rd = 1'b0; end
      m_prev_sel = spi_select;
    end
  end

  // Bus monitor: logs accesses, checks access shape, counts done pulses
  logic        log_w [256];
  logic [2:0]  log_a [256];
  logic [15:0] log_d [256];
  int          log_gap [256];
  int          log_n = 0, done_cnt = 0, wr1_cnt = 0, run = 0, zero = 0;
  bit          bad = 0;
  logic [2:0]  p_a;
  logic [15:0] p_d;
  logic        p_r, p_w;

  always @(negedge clk) begin
    if (!reset_n) begin
      run = 0; zero = 0; bad = 0;
    end else begin
      if (done) done_cnt++;
      if (spi_select) begin
        if (run == 0) begin
          log_w[log_n] = !write_n; log_a[log_n] = mem_addr; log_d[log_n] = spi_wrdata;
          log_gap[log_n] = zero; log_n++;
          if (!write_n && mem_addr == 3'd1) wr1_cnt++;
          p_a = mem_addr; p_d = spi_wrdata; p_r = read_n; p_w = write_n;
        end else if (mem_addr != p_a || spi_wrdata != p_d || read_n != p_r || write_n != p_w) begin
          bad = 1;
        end
        if (read_n == write_n) bad = 1;
        run++; zero = 0;
      end else begin
        if (run > 0) chk(run == 2 && !bad, "access_shape", 64'(run), 64'd2);
        run = 0; bad = 0; zero++;
      end
    end
  end

  task automatic run_cmd(input logic [2:0] l, input logic [31:0] tx, input logic [31:0] exp_rx,
                         input logic exp_err, input bit to);
    logic        e_w [16];
    logic [2:0]  e_a [16];
    logic [15:0] e_d [16];
    int en, lb, db, n;
    bit good;
    good = (l >= 3'd1 && l <= 3'd4);
    en = 0;
    if (good) begin
      e_w[en] = 1; e_a[en] = 3'd3; e_d[en] = 16'h0400; en++;
      e_w[en] = 1; e_a[en] = 3'd2; e_d[en] = 16'h0000; en++;
      for (int b = 0; b < int'(l); b++) begin
        e_w[en] = 1; e_a[en] = 3'd1; e_d[en] = {8'h00, tx[8*b +: 8]}; en++;
        if (to) break;
        e_w[en] = 0; e_a[en] = 3'd0; e_d[en] = 16'h0000; en++;
      end
      e_w[en] = 1; e_a[en] = 3'd3; e_d[en] = 16'h0000; en++;
    end
    lb = log_n; db = done_cnt;
    @(posedge clk); #1 start = 1; len = l; tx_data = tx;
    @(posedge clk); #1 start = 0; len = 3'($urandom); tx_data = $urandom;
    @(negedge clk);
    if (good) chk(busy === 1'b1 && done === 1'b0, "busy_after_start", {busy, done}, 64'b10);
    else      chk(done === 1'b1 && err === 1'b1 && busy === 1'b0, "bad_len_done", {done, err, busy}, 64'b110);
    n = 0;
    while (done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    chk(done === 1'b1, "done_seen", 64'(done), 64'd1);
    chk(busy === 1'b0, "busy_at_done", 64'(busy), 64'd0);
    chk(err === exp_err, "err", 64'(err), 64'(exp_err));
    chk(rx_data === exp_rx, "rx_data", 64'(rx_data), 64'(exp_rx));
    @(negedge clk);
    chk(done === 1'b0, "done_one_cycle", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk(done_cnt - db == 1, "done_count", 64'(done_cnt - db), 64'd1);
    chk(log_n - lb == en, "access_count", 64'(log_n - lb), 64'(en));
    for (int i = 0; i < en && i < log_n - lb; i++)
      chk(log_w[lb+i] == e_w[i] && log_a[lb+i] == e_a[i] && (!e_w[i] || log_d[lb+i] == e_d[i]),
          "access", {log_w[lb+i], log_a[lb+i], log_d[lb+i]}, {e_w[i], e_a[i], e_d[i]});
    if (good) chk(m_sso == 1'b0, "ss_released", 64'(m_sso), 64'd0);
    if (to && log_n - lb == en) chk(log_gap[lb+en-1] == 21, "timeout_gap", 64'(log_gap[lb+en-1]), 64'd21);
  endtask

  typedef struct {
    logic [2:0]  l;
    logic [31:0] tx;
    logic [31:0] exp_rx;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];
  int n, lb, db, wb;

  initial begin
    vecs[0] = '{3'd1, 32'h000000A5, 32'h000000A5, 1'b0};
    vecs[1] = '{3'd4, 32'h44332211, 32'h44332211, 1'b0};
    vecs[2] = '{3'd2, 32'h1234BEEF, 32'h4433BEEF, 1'b0};
    vecs[3] = '{3'd0, 32'hFFFFFFFF, 32'h4433BEEF, 1'b1};
    vecs[4] = '{3'd5, 32'hFFFFFFFF, 32'h4433BEEF, 1'b1};
    vecs[5] = '{3'd3, 32'h99C0FFEE, 32'h44C0FFEE, 1'b0};
    vecs[6] = '{3'd7, 32'h01020304, 32'h44C0FFEE, 1'b1};

    repeat (3) @(negedge clk);
    chk({busy, done, err, spi_select, read_n, write_n} === 6'b000011 && mem_addr === 3'd0,
        "reset_ctrl", {busy, done, err, spi_select, read_n, write_n, mem_addr}, 64'b000011000);
    chk(rx_data === 32'd0 && spi_wrdata === 16'd0, "reset_data", {spi_wrdata, rx_data}, 64'd0);
    @(posedge clk); #1 reset_n = 1;

    for (int v = 0; v < 7; v++) run_cmd(vecs[v].l, vecs[v].tx, vecs[v].exp_rx, vecs[v].exp_err, 0);

    // stalled receive: rrdy never rises, command must time out and release SS_n
    rrdy_en = 0;
    run_cmd(3'd1, 32'h00000077, 32'h44C0FFEE, 1'b1, 1);
    rrdy_en = 1;

    // reset during the second byte of a three-byte command
    wb = wr1_cnt;
    @(posedge clk); #1 start = 1; len = 3'd3; tx_data = 32'h00332211;
    @(posedge clk); #1 start = 0;
    n = 0;
    while (wr1_cnt - wb < 2 && n < 400) begin @(negedge clk); n++; end
    chk(wr1_cnt - wb == 2, "reached_byte2", 64'(wr1_cnt - wb), 64'd2);
    @(posedge clk); #2 reset_n = 0;
    #1;
    chk({busy, done, err, spi_select, read_n, write_n} === 6'b000011 && mem_addr === 3'd0,
        "midreset_ctrl", {busy, done, err, spi_select, read_n, write_n, mem_addr}, 64'b000011000);
    chk(rx_data === 32'd0 && spi_wrdata === 16'd0, "midreset_data", {spi_wrdata, rx_data}, 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset_n = 1;
    lb = log_n; db = done_cnt;
    repeat (40) @(negedge clk);
    chk(done_cnt == db, "no_done_after_reset", 64'(done_cnt - db), 64'd0);
    chk(log_n == lb, "no_access_after_reset", 64'(log_n - lb), 64'd0);
    run_cmd(3'd1, 32'h000000A5, 32'h000000A5, 1'b0, 0);

    // second start while busy is ignored
    lb = log_n; db = done_cnt;
    @(posedge clk); #1 start = 1; len = 3'd2; tx_data = 32'h0000BBAA;
    @(posedge clk); #1 start = 0; len = 3'd4; tx_data = 32'hDEADBEEF;
    repeat (4) @(posedge clk);
    #1 start = 1; len = 3'd1; tx_data = 32'h000000FF;
    @(posedge clk); #1 start = 0;
    n = 0;
    while (done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    chk(done === 1'b1, "busy_done_seen", 64'(done), 64'd1);
    chk(err === 1'b0, "busy_err", 64'(err), 64'd0);
    chk(rx_data === 32'h0000BBAA, "busy_rx_data", 64'(rx_data), 64'h0000BBAA);
    repeat (10) @(negedge clk);
    chk(done_cnt - db == 1, "busy_done_count", 64'(done_cnt - db), 64'd1);
    chk(log_n - lb == 7, "busy_access_count", 64'(log_n - lb), 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
